organ_voice_alloc: RTL and testbench
====================================

Name: organ_voice_alloc

Overview:
- Polyphony controller between midi_in note strobes and the organ key-mask datapath.
- Maps incoming note on/off events onto a fixed pool of VOICES voices, using reuse, then free, then LRU-steal allocation.
- Implements sustain-pedal hold and all-notes-off.
- Publishes per-voice note/velocity/gate plus a 128-bit key mask that replaces direct keys[NOTE] writes.

Parameters:
- VOICES, 8, number of voices; legal range 2..16.
- RW, 4, rank/index width; must be >= clog2(VOICES).
- QDEPTH, 2, event FIFO depth; power of two.

Ports:
- clk  in  1  system clock (50 MHz domain)
- rst_n  in  1  asynchronous active-low reset
- note_on  in  1  one-cycle strobe; note/vel valid
- note_off  in  1  one-cycle strobe; note valid
- note  in  7  MIDI note number
- vel  in  7  MIDI velocity
- sustain  in  1  pedal level (CC64 >= 64), held stable by upstream
- all_off  in  1  one-cycle strobe (CC123 or panic)
- voice_gate  out  VOICES  per-voice gate
- voice_note  out  7*VOICES  voice v note at [7v+6:7v]
- voice_vel  out  7*VOICES  voice v velocity
- voice_trig  out  VOICES  one-cycle pulse on (re)assignment
- keys  out  128  OR of notes of gated voices
- busy  out  1  FSM not IDLE or FIFO not empty
- overflow  out  1  one-cycle pulse when an event is dropped
- drop_cnt  out  8  saturating count of dropped events

Behaviour:
- Reset (async, rst_n=0): all outputs 0; FIFO empty; FSM IDLE; voice state cleared (down=0, held=0); ranks v = v.
- Per-voice state: note, vel, down, held, rank. voice_gate = down|held (registered).
- Input capture:
  - note_off wins over a simultaneous note_on. The off event is enqueued; the on event is counted as a drop.
  - all_off wins over everything. Same-cycle events are discarded and not counted.
- Event FIFO: QDEPTH entries of {type, note, vel}. Enqueue when full -> event dropped, overflow pulse, drop_cnt+1, saturating at 255.
- all_off, next edge: FIFO flushed, FSM forced to IDLE (aborts in-flight scan), all down/held cleared, ranks untouched. keys=0 one cycle later.
- Sustain edge detector (registered sustain):
  - On a falling edge, all held bits clear in that cycle.
  - This is independent of the FSM; if a scan is in flight, it uses the updated bits.
- FSM states and transitions:
  - IDLE: if FIFO non-empty, pop -> SCAN, idx=0.
  - SCAN: one voice per cycle, idx 0..VOICES-1; then -> COMMIT. It records:
    - match: first voice with same note and (down|held).
    - free: first voice with down=0 and held=0.
    - oldest: voice with rank = VOICES-1.
  - COMMIT (1 cycle) -> IDLE.
    - on event, target voice = match, else free, else oldest. Write note/vel, down=1, held=0. Pulse voice_trig[target]. LRU update: target rank 0; voices whose rank < old target rank increment.
    - off event: if match exists with down=1, then sustain=1 -> down=0, held=1; sustain=0 -> down=0. Otherwise no change, with no drop or overflow.
- Latency: strobe at cycle 0 with FIFO empty and FSM in IDLE -> voice_gate/voice_trig change at cycle VOICES+3; keys one cycle later. Throughput is one event per VOICES+2 cycles.
- Ranks always form a permutation of 0..VOICES-1.
- keys: bitwise OR over v of (voice_gate[v] << voice_note[v]), registered. Duplicate notes cannot occur because of the match rule.

Decomposition:
- Shared package organ_pkg holds:
  - event-type encoding (EV_ON=1'b1, EV_OFF=1'b0)
  - MIDI constants (CC_SUSTAIN=64, CC_ALL_OFF=123)
  - the 128-bit key-mask width
- Sub-module organ_evt_fifo (QDEPTH x 15 bits, full/empty flags, synchronous flush) is instantiated once.
- FSM, voice table and key-mask OR stay in the top.

Test Plan:
- Reset, then note_on 60 vel 100 -> voice 0 gate=1, note=60, trig pulse at cycle VOICES+3; keys[60]=1 one cycle later.
- 9 note_ons (notes 60..68) with VOICES=8 -> note 68 steals voice 0 (oldest, note 60); keys[60]=0, keys[68]=1; each trig asserted once.
- sustain=1, note_on 64, note_off 64 -> gate stays 1 (held); sustain falls -> gate 0 next cycle, keys[64]=0.
- note_on 64 twice -> same voice retriggered (two trig pulses, one voice gated); note_off 70 (not allocated) -> no state change.
- 4 strobes back-to-back, one per cycle, with QDEPTH=2 -> the 4th strobe is dropped (the 1st pops into the FSM, the 2nd and 3rd fill the FIFO); overflow pulses once, drop_cnt=1; note_on+note_off same cycle -> only the off is processed, drop_cnt+1.
- all_off mid-SCAN, and rst_n low mid-SCAN -> all gates/keys 0, FIFO empty, busy=0; the next note_on lands on the free voice with the lowest index.

Source files
------------

// File: rtl/organ_pkg.sv
// Shared constants and the queued event record for the organ voice allocator.
package organ_pkg;
  localparam logic EV_ON  = 1'b1;
  localparam logic EV_OFF = 1'b0;

  localparam int CC_SUSTAIN = 64;
  localparam int CC_ALL_OFF = 123;

  localparam int KEY_W = 128;

  typedef struct packed {
    logic       typ;
    logic [6:0] note;
    logic [6:0] vel;
  } evt_t;

  localparam int EVT_W = $bits(evt_t);
endpackage

// File: rtl/organ_evt_fifo.sv
// Small event FIFO between the MIDI strobes and the allocator FSM; flush wins over push/pop.
module organ_evt_fifo
  import organ_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [EVT_W-1:0] din,
  output logic [EVT_W-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(QDEPTH);

  logic [EVT_W-1:0] mem [QDEPTH];
  logic [AW:0]      wp, rp;
  logic             do_push, do_pop;

  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign empty   = (wp == rp);
  assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign dout    = mem[rp[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + (AW+1)'(1);
      if (do_pop)  rp <= rp + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp[AW-1:0]] <= din;
  end
endmodule

// File: rtl/organ_voice_alloc.sv
// Polyphonic voice allocator: reuse, then free, then LRU steal; sustain hold and all-notes-off.
//   state    | meaning
//   S_IDLE   | waiting for a queued event, pops it when present
//   S_SCAN   | walks one voice per cycle recording match/free/oldest
//   S_COMMIT | applies the event to the chosen voice, updates LRU ranks
module organ_voice_alloc
  import organ_pkg::*;
#(
  parameter int VOICES = 8,
  parameter int RW     = 4,
  parameter int QDEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  note_on,
  input  logic                  note_off,
  input  logic [6:0]            note,
  input  logic [6:0]            vel,
  input  logic                  sustain,
  input  logic                  all_off,
  output logic [VOICES-1:0]     voice_gate,
  output logic [7*VOICES-1:0]   voice_note,
  output logic [7*VOICES-1:0]   voice_vel,
  output logic [VOICES-1:0]     voice_trig,
  output logic [KEY_W-1:0]      keys,
  output logic                  busy,
  output logic                  overflow,
  output logic [7:0]            drop_cnt
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SCAN   = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;

  logic [1:0]        state;
  logic [RW-1:0]     idx, m_idx, f_idx, o_idx, tgt, tgt_rank;
  logic              m_found, f_found, tgt_down;
  evt_t              cur, head, in_evt;
  logic [EVT_W-1:0]  head_raw;
  logic              fifo_full, fifo_empty, push, pop, want;
  logic              sus_q, sus_fall;
  logic [1:0]        n_drop;
  logic [8:0]        drop_sum;
  logic [6:0]        sc_note;
  logic              sc_used, sc_old;
  logic [KEY_W-1:0]  keys_nx;

  logic [6:0]        v_note [VOICES];
  logic [6:0]        v_vel  [VOICES];
  logic [RW-1:0]     v_rank [VOICES];
  logic [VOICES-1:0] v_down, v_held;

  // note_off beats note_on; all_off discards everything silently
  always_comb begin
    in_evt   = '{typ: note_off ? EV_OFF : EV_ON, note: note, vel: vel};
    want     = (note_on | note_off) & ~all_off;
    push     = want & ~fifo_full;
    n_drop   = 2'd0;
    if (!all_off && note_on && note_off) n_drop = n_drop + 2'd1;
    if (want && fifo_full)               n_drop = n_drop + 2'd1;
    drop_sum = {1'b0, drop_cnt} + {7'd0, n_drop};
  end

  assign pop      = (state == S_IDLE) & ~fifo_empty & ~all_off;
  assign head     = head_raw;
  assign sus_fall = sus_q & ~sustain;
  assign busy     = (state != S_IDLE) | ~fifo_empty;
  assign voice_gate = v_down | v_held;

  organ_evt_fifo #(.QDEPTH(QDEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (all_off),
    .push  (push),
    .pop   (pop),
    .din   (in_evt),
    .dout  (head_raw),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    sc_note  = '0;
    sc_used  = 1'b0;
    sc_old   = 1'b0;
    tgt_rank = '0;
    tgt_down = 1'b0;
    tgt      = m_found ? m_idx : (f_found ? f_idx : o_idx);
    for (int v = 0; v < VOICES; v++) begin
      if (idx == RW'(v)) begin
        sc_note = v_note[v];
        sc_used = v_down[v] | v_held[v];
        sc_old  = (v_rank[v] == RW'(VOICES-1));
      end
      if (tgt == RW'(v)) begin
        tgt_rank = v_rank[v];
        tgt_down = v_down[v];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      idx     <= '0;
      m_idx   <= '0;
      f_idx   <= '0;
      o_idx   <= '0;
      m_found <= 1'b0;
      f_found <= 1'b0;
      cur     <= '0;
    end else if (all_off) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (!fifo_empty) begin
          cur     <= head;
          idx     <= '0;
          m_found <= 1'b0;
          f_found <= 1'b0;
          state   <= S_SCAN;
        end
        S_SCAN: begin
          if (!m_found && sc_used && sc_note == cur.note) begin
            m_found <= 1'b1;
            m_idx   <= idx;
          end
          if (!f_found && !sc_used) begin
            f_found <= 1'b1;
            f_idx   <= idx;
          end
          if (sc_old) o_idx <= idx;
          if (idx == RW'(VOICES-1)) state <= S_COMMIT;
          else                      idx   <= idx + RW'(1);
        end
        S_COMMIT: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  // held bits drop on the pedal release edge regardless of where the FSM is
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sus_q      <= 1'b0;
      v_down     <= '0;
      v_held     <= '0;
      voice_trig <= '0;
      for (int v = 0; v < VOICES; v++) begin
        v_note[v] <= '0;
        v_vel[v]  <= '0;
        v_rank[v] <= RW'(v);
      end
    end else begin
      sus_q      <= sustain;
      voice_trig <= '0;
      if (all_off) begin
        v_down <= '0;
        v_held <= '0;
      end else begin
        if (sus_fall) v_held <= '0;
        if (state == S_COMMIT) begin
          if (cur.typ == EV_ON) begin
            for (int v = 0; v < VOICES; v++) begin
              if (tgt == RW'(v)) begin
                v_note[v]     <= cur.note;
                v_vel[v]      <= cur.vel;
                v_down[v]     <= 1'b1;
                v_held[v]     <= 1'b0;
                v_rank[v]     <= '0;
                voice_trig[v] <= 1'b1;
              end else if (v_rank[v] < tgt_rank) begin
                v_rank[v] <= v_rank[v] + RW'(1);
              end
            end
          end else if (m_found && tgt_down) begin
            for (int v = 0; v < VOICES; v++) begin
              if (m_idx == RW'(v)) begin
                v_down[v] <= 1'b0;
                v_held[v] <= sustain;
              end
            end
          end
        end
      end
    end
  end

  always_comb begin
    voice_note = '0;
    voice_vel  = '0;
    keys_nx    = '0;
    for (int v = 0; v < VOICES; v++) begin
      voice_note[7*v +: 7] = v_note[v];
      voice_vel[7*v +: 7]  = v_vel[v];
      if (voice_gate[v]) keys_nx[v_note[v]] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
      keys     <= '0;
    end else begin
      overflow <= (n_drop != 2'd0);
      if (n_drop != 2'd0) drop_cnt <= (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
      keys <= keys_nx;
    end
  end
endmodule

// File: tb/tb_organ_voice_alloc.sv
// Scoreboard bench for organ_voice_alloc: expected triggers queued at stimulus, popped on voice_trig.
module tb_organ_voice_alloc;
  localparam int VOICES = 8;
  localparam int RW     = 4;
  localparam int QDEPTH = 2;

  logic                clk = 1'b0;
  logic                rst_n, note_on, note_off, sustain, all_off;
  logic [6:0]          note, vel;
  logic [VOICES-1:0]   voice_gate, voice_trig;
  logic [7*VOICES-1:0] voice_note, voice_vel;
  logic [127:0]        keys;
  logic                busy, overflow;
  logic [7:0]          drop_cnt;

  organ_voice_alloc #(.VOICES(VOICES), .RW(RW), .QDEPTH(QDEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .note_on(note_on), .note_off(note_off),
    .note(note), .vel(vel), .sustain(sustain), .all_off(all_off),
    .voice_gate(voice_gate), .voice_note(voice_note), .voice_vel(voice_vel),
    .voice_trig(voice_trig), .keys(keys), .busy(busy), .overflow(overflow),
    .drop_cnt(drop_cnt)
  );

  always #10 clk = ~clk;

  typedef struct { int voice; int note; } exp_t;
  exp_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;

  int m_note [VOICES];
  int m_rank [VOICES];
  bit m_down [VOICES];
  bit m_held [VOICES];
  bit m_sus;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int v = 0; v < VOICES; v++) begin
      m_note[v] = 0; m_rank[v] = v; m_down[v] = 0; m_held[v] = 0;
    end
    m_sus = 0;
  endfunction

  function automatic void model_on(int n);
    int t = -1;
    int old;
    for (int v = 0; v < VOICES; v++)
      if (t < 0 && m_note[v] == n && (m_down[v] || m_held[v])) t = v;
    for (int v = 0; v < VOICES; v++)
      if (t < 0 && !m_down[v] && !m_held[v]) t = v;
    for (int v = 0; v < VOICES; v++)
      if (t < 0 && m_rank[v] == VOICES-1) t = v;
    old = m_rank[t];
    for (int v = 0; v < VOICES; v++)
      if (v != t && m_rank[v] < old) m_rank[v]++;
    m_rank[t] = 0; m_note[t] = n; m_down[t] = 1; m_held[t] = 0;
    sb.push_back('{t, n});
  endfunction

  function automatic void model_off(int n);
    bit done = 0;
    for (int v = 0; v < VOICES; v++) begin
      if (!done && m_note[v] == n && (m_down[v] || m_held[v])) begin
        done = 1;
        if (m_down[v]) begin m_down[v] = 0; m_held[v] = m_sus; end
      end
    end
  endfunction

  function automatic void model_clear();
    for (int v = 0; v < VOICES; v++) begin m_down[v] = 0; m_held[v] = 0; end
  endfunction

  function automatic logic [VOICES-1:0] model_gate();
    logic [VOICES-1:0] g = '0;
    for (int v = 0; v < VOICES; v++) g[v] = m_down[v] | m_held[v];
    return g;
  endfunction

  function automatic logic [127:0] model_keys();
    logic [127:0] k = '0;
    for (int v = 0; v < VOICES; v++) if (m_down[v] || m_held[v]) k[m_note[v]] = 1'b1;
    return k;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input bit on, input bit off, input int n, input int vl);
    note_on = on; note_off = off; note = 7'(n); vel = 7'(vl);
    tick();
    note_on = 1'b0; note_off = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 400) begin tick(); k++; end
    chk("idle_timeout", busy, 0);
    tick();
  endtask

  // trigger monitor: each pulse must match the oldest outstanding expectation
  always @(posedge clk) begin
    int   hit;
    exp_t e;
    #2;
    if (rst_n && voice_trig != '0) begin
      hit = -1;
      for (int v = VOICES-1; v >= 0; v--) if (voice_trig[v]) hit = v;
      chk("trig_onehot", $countones(voice_trig), 1);
      if (sb.size() == 0) chk("trig_unexpected", voice_trig, 0);
      else begin
        e = sb.pop_front();
        chk("trig_voice", hit, e.voice);
        chk("trig_note", voice_note[7*hit +: 7], e.note);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 0; note_on = 0; note_off = 0; note = 0; vel = 0; sustain = 0; all_off = 0;
    model_reset();
    #15;
    chk("rst_gate", voice_gate, 0);
    chk("rst_trig", voice_trig, 0);
    chk("rst_keys", keys, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_drop", drop_cnt, 0);
    tick(); rst_n = 1; tick();

    // first note: exact latency
    model_on(60);
    strobe(1, 0, 60, 100);
    repeat (VOICES+1) tick();
    chk("lat_gate_early", voice_gate, 0);
    tick();
    chk("lat_trig", voice_trig, 1);
    chk("lat_gate", voice_gate, model_gate());
    chk("lat_note", voice_note[6:0], 60);
    chk("lat_vel", voice_vel[6:0], 100);
    chk("lat_keys_early", keys, 0);
    tick();
    chk("lat_keys", keys, model_keys());

    // fill pool then steal the oldest
    for (int n = 61; n <= 68; n++) begin
      model_on(n);
      strobe(1, 0, n, 80);
      wait_idle();
    end
    chk("steal_gate", voice_gate, model_gate());
    chk("steal_keys", keys, model_keys());
    chk("steal_v0_note", voice_note[6:0], 68);

    all_off = 1; tick(); all_off = 0; model_clear(); tick();
    chk("alloff_gate", voice_gate, model_gate());
    chk("alloff_keys", keys, 0);

    // sustain hold and release
    sustain = 1; m_sus = 1; tick();
    model_on(64); strobe(1, 0, 64, 70); wait_idle();
    model_off(64); strobe(0, 1, 64, 0); wait_idle();
    chk("sus_hold_gate", voice_gate, model_gate());
    chk("sus_hold_keys", keys, model_keys());
    sustain = 0; m_sus = 0; model_clear(); tick();
    chk("sus_rel_gate", voice_gate, model_gate());
    tick();
    chk("sus_rel_keys", keys, model_keys());

    // retrigger same note, off for an unallocated note
    model_on(64); strobe(1, 0, 64, 50); wait_idle();
    model_on(64); strobe(1, 0, 64, 60); wait_idle();
    chk("retrig_gate", voice_gate, model_gate());
    chk("retrig_onehot", $countones(voice_gate), 1);
    model_off(70); strobe(0, 1, 70, 0); wait_idle();
    chk("off_unalloc_gate", voice_gate, model_gate());
    chk("off_unalloc_drop", drop_cnt, 0);
    model_off(64); strobe(0, 1, 64, 0); wait_idle();
    chk("off64_gate", voice_gate, model_gate());

    // back-to-back overflow
    model_on(40); model_on(41); model_on(42);
    strobe(1, 0, 40, 90);
    strobe(1, 0, 41, 90);
    strobe(1, 0, 42, 90);
    chk("ovf_early", overflow, 0);
    strobe(1, 0, 43, 90);
    chk("ovf_pulse", overflow, 1);
    chk("drop_one", drop_cnt, 1);
    tick();
    chk("ovf_clear", overflow, 0);
    wait_idle();
    chk("b2b_gate", voice_gate, model_gate());
    chk("b2b_keys", keys, model_keys());
    model_off(41);
    strobe(1, 1, 41, 90);
    chk("drop_onoff", drop_cnt, 2);
    wait_idle();
    chk("onoff_gate", voice_gate, model_gate());

    // all_off during a scan
    strobe(1, 0, 50, 90);
    repeat (3) tick();
    chk("mid_scan_busy", busy, 1);
    all_off = 1; tick(); all_off = 0; model_clear();
    chk("abort_busy", busy, 0);
    chk("abort_gate", voice_gate, 0);
    tick();
    chk("abort_keys", keys, 0);
    model_on(51); strobe(1, 0, 51, 90); wait_idle();
    chk("after_abort_note", voice_note[6:0], 51);
    chk("after_abort_gate", voice_gate, model_gate());

    // reset during a scan
    strobe(1, 0, 52, 90);
    repeat (3) tick();
    rst_n = 0; #1;
    chk("rst_mid_gate", voice_gate, 0);
    chk("rst_mid_keys", keys, 0);
    chk("rst_mid_busy", busy, 0);
    tick(); rst_n = 1; model_reset(); tick();
    chk("rst_mid_drop", drop_cnt, 0);
    model_on(53); strobe(1, 0, 53, 90); wait_idle();
    chk("after_rst_note", voice_note[6:0], 53);
    chk("after_rst_gate", voice_gate, model_gate());
    chk("after_rst_keys", keys, model_keys());

    repeat (2) tick();
    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
